uart_receiver: RTL
==================

// Module: uart_receiver
// PURPOSE
//  Downstream partner of the UART transmitter. Recovers 8N1 frames from a serial line.
//  Samples the line on an oversampling tick from baud_rate_gen (OVERSAMPLE ticks per bit).
//  Presents each received byte on a valid/ready handshake, with framing and overrun status.
//  Sits between the serial pin (or a transmitter's serial_out in loopback) and the byte consumer.
// PARAMETERS
//  OVERSAMPLE  16  ticks per bit period; even, >=4
//  DATA_BITS   8   data bits per frame, LSB first
// PORTS
//  clk          in   1          system clock, single clock domain
//  rst          in   1          asynchronous, active-high reset
//  tick         in   1          oversample enable, 1-clk pulse from baud_rate_gen
//  serial_in    in   1          asynchronous serial line, idle high
//  rx_data      out  DATA_BITS  received byte, stable while rx_valid=1
//  rx_valid     out  1          byte available; held until accepted
//  rx_ready     in   1          consumer accepts byte when rx_valid & rx_ready at posedge clk
//  framing_err  out  1          stop bit of held byte sampled 0; qualified by rx_valid
//  parity_err   out  1          parity mismatch of held byte (see CONFIGURATION)
//  overrun      out  1          1-clk pulse: a frame completed while the previous byte was unaccepted
// BEHAVIOUR
//  Reset values: rx_data=0, rx_valid=0, framing_err=0, parity_err=0, overrun=0, state=IDLE, sync flops=1.
//  serial_in passes through a 2-flop synchronizer (reset to 1). All FSM logic uses the synced value.
//  Tick counter and bit counter advance only on cycles with tick=1.
//  FSM states:
//   IDLE:   on a falling edge of the synced line (prev 1, now 0) -> START, tick_cnt=0.
//   START:  at tick_cnt==OVERSAMPLE/2-1 (mid-bit), sample the line.
//           0 -> DATA with tick_cnt=0, bit_cnt=0.
//           1 -> IDLE (glitch rejected, no output).
//   DATA:   at tick_cnt==OVERSAMPLE-1, sample and shift into shreg LSB-first and reset tick_cnt.
//           After bit DATA_BITS-1 -> STOP, or -> PARITY when PARITY_EN is defined.
//   PARITY: same sample point as DATA; store the bit -> STOP.
//   STOP:   at tick_cnt==OVERSAMPLE-1, sample the line -> frame complete -> IDLE.
//           A 0 here (break/framing) gives framing_err=1.
//           IDLE still requires a new falling edge, so a held-low line produces no new frames.
//  Frame completion, on the clk after the stop-sample tick:
//   rx_valid=0, or rx_valid=1 & rx_ready=1 in the same cycle:
//     load rx_data, framing_err and parity_err; rx_valid=1.
//   rx_valid=1 & rx_ready=0:
//     drop the new byte, keep the held byte and its flags, pulse overrun for 1 clk.
//  Acceptance with no completion in the same cycle -> rx_valid=0 on the next clk.
//  Flags are not cleared on accept; they are only meaningful while rx_valid=1.
//  Latency: rx_valid rises 1 clk after the stop-bit mid-sample tick.
//  Counter widths: $clog2(OVERSAMPLE) for tick_cnt and $clog2(DATA_BITS+1) for bit_cnt. No wrap beyond terminal count.
//  Reset mid-frame: everything returns to reset values immediately and the partial byte is discarded.
//  rx_ready while rx_valid=0 is ignored. A tick held high every clk is legal (maximum rate).
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//    Frame is start + DATA_BITS + even-parity bit + stop.
//    parity_err=1 when XOR(data bits, parity bit)=1.
//  Not defined:
//    No PARITY state; 8N1 frame only; parity_err tied 0.
// STRUCTURE
//  uart_pkg (shared with the transmitter):
//    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
//    localparam UART_DATA_BITS=8, UART_OVERSAMPLE=16.
//  Sub-module uart_rx_sync: 2-flop synchronizer, reset value 1. Its output feeds the edge detect and FSM.
//  Everything else is in this module: FSM, counters, shift register, output holding register.
// TESTING  (tick=1 every clk, OVERSAMPLE=16, so 16 clk per bit)
//  1. Send 0xA5 as 8N1 with rx_ready=1
//     -> rx_valid pulses 1 clk with rx_data=0xA5, framing_err=0, overrun never asserted.
//  2. Drive the line low for 4 clk, then high
//     -> START rejects it and returns to IDLE; rx_valid stays 0; a following 0x3C is received correctly.
//  3. Send 0x81 with the stop bit driven 0
//     -> rx_valid=1, rx_data=0x81, framing_err=1; no further frame while the line stays low.
//  4. rx_ready=0; send 0x11 then 0x22 back-to-back
//     -> rx_data holds 0x11, overrun pulses once at the end of 0x22;
//        raising rx_ready clears rx_valid next clk.
//  5. Assert rst during bit 4 of 0xF0
//     -> outputs read reset values on the next clk; a subsequent 0x5A is received cleanly.
//  6. UART_RX_PARITY_EN defined: send 0x07 with parity bit 1 -> parity_err=0;
//     send 0x07 with parity bit 0 -> parity_err=1.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by both the transmitter and the receiver.
//   UART_DATA_BITS  : default number of data bits per frame (LSB first)
//   UART_OVERSAMPLE : default number of oversample ticks per bit period
//   rx_state_t      : receiver FSM state encoding
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int UART_DATA_BITS  = 8;
   localparam int UART_OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4
   } rx_state_t;

endpackage : uart_pkg

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer bringing the asynchronous serial line into the clk
// domain. Both flops reset to 1 so the line reads idle (high) out of reset
// and no false start edge is seen when reset is released.
// Ports:
//   clk    in  system clock
//   rst    in  asynchronous active-high reset
//   line   in  asynchronous serial line
//   synced out synchronized copy of line (2 clk latency)
// -----------------------------------------------------------------------------
module uart_rx_sync
   import uart_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic line,
   output logic synced
);

   logic meta_r;
   logic sync_r;

   // Two-stage synchronizer chain, idle-high reset value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_r <= 1'b1;
         sync_r <= 1'b1;
      end else begin
         meta_r <= line;
         sync_r <= meta_r;
      end
   end

   assign synced = sync_r;

endmodule : uart_rx_sync

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// Recovers start + DATA_BITS + [parity] + stop frames from a serial line that
// is sampled on an oversample tick (OVERSAMPLE ticks per bit). Each received
// byte is presented on a valid/ready handshake together with framing and
// parity status; a frame that completes while the previous byte is still
// unaccepted is dropped and signalled by a one-clock overrun pulse.
//
// Build option: define UART_RX_PARITY_EN to expect an even-parity bit between
// the last data bit and the stop bit. Without it the frame is 8N1 and
// parity_err is tied low.
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   tick        in   oversample enable, one-clk pulse per oversample period
//   serial_in   in   asynchronous serial line, idle high
//   rx_data     out  received byte, stable while rx_valid=1
//   rx_valid    out  byte available, held until accepted
//   rx_ready    in   consumer accepts when rx_valid & rx_ready at posedge clk
//   framing_err out  stop bit of the held byte sampled 0
//   parity_err  out  parity mismatch of the held byte
//   overrun     out  one-clk pulse: frame completed while byte unaccepted
// -----------------------------------------------------------------------------
module uart_receiver
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = UART_OVERSAMPLE,
   parameter int DATA_BITS  = UART_DATA_BITS
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick,
   input  logic                 serial_in,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 framing_err,
   output logic                 parity_err,
   output logic                 overrun
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);

   localparam logic [TW-1:0] TICK_ZERO = TW'(0);
   localparam logic [TW-1:0] TICK_ONE  = TW'(1);
   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_ZERO  = BW'(0);
   localparam logic [BW-1:0] BIT_ONE   = BW'(1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   localparam logic [2:0] ST_IDLE   = RX_IDLE;
   localparam logic [2:0] ST_START  = RX_START;
   localparam logic [2:0] ST_DATA   = RX_DATA;
   localparam logic [2:0] ST_PARITY = RX_PARITY;
   localparam logic [2:0] ST_STOP   = RX_STOP;

   logic                 line_s;
   logic                 prev_r;
   logic                 fall_s;
   logic [2:0]           state_r;
   logic [TW-1:0]        tick_cnt_r;
   logic [BW-1:0]        bit_cnt_r;
   logic [DATA_BITS-1:0] shreg_r;
   logic                 frame_done_s;
   logic                 load_s;
   logic [DATA_BITS-1:0] rx_data_r;
   logic                 rx_valid_r;
   logic                 framing_err_r;
   logic                 overrun_r;

   uart_rx_sync u_sync (
      .clk    (clk),
      .rst    (rst),
      .line   (serial_in),
      .synced (line_s)
   );

   // Previous synced line value for start-edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_r <= 1'b1;
      end else begin
         prev_r <= line_s;
      end
   end

   assign fall_s = prev_r & ~line_s;

   // The stop bit is sampled combinationally in the terminal tick cycle so the
   // holding register can load on that same edge (rx_valid one clk later).
   assign frame_done_s = (state_r == ST_STOP) && tick && (tick_cnt_r == TICK_LAST);
   assign load_s       = frame_done_s && (!rx_valid_r || rx_ready);

`ifdef UART_RX_PARITY_EN
   logic parity_bit_r;
   logic parity_err_r;

   // Even parity: XOR over data and parity bit must be 0.
   function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] data,
                                            input logic                 par);
      return (^data) ^ par;
   endfunction
`endif

   // Receive FSM: start qualification, data shift, optional parity, stop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         tick_cnt_r <= TICK_ZERO;
         bit_cnt_r  <= BIT_ZERO;
         shreg_r    <= '0;
`ifdef UART_RX_PARITY_EN
         parity_bit_r <= 1'b0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               // A new falling edge is required, so a line held low after a
               // framing error never restarts the FSM.
               if (fall_s) begin
                  state_r    <= ST_START;
                  tick_cnt_r <= TICK_ZERO;
               end
            end
            ST_START: begin
               if (tick) begin
                  if (tick_cnt_r == TICK_MID) begin
                     if (!line_s) begin
                        state_r    <= ST_DATA;
                        tick_cnt_r <= TICK_ZERO;
                        bit_cnt_r  <= BIT_ZERO;
                     end else begin
                        // Line went back high before mid-bit: glitch.
                        state_r <= ST_IDLE;
                     end
                  end else begin
                     tick_cnt_r <= tick_cnt_r + TICK_ONE;
                  end
               end
            end
            ST_DATA: begin
               if (tick) begin
                  if (tick_cnt_r == TICK_LAST) begin
                     shreg_r    <= {line_s, shreg_r[DATA_BITS-1:1]};
                     tick_cnt_r <= TICK_ZERO;
                     if (bit_cnt_r == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_r <= ST_PARITY;
`else
                        state_r <= ST_STOP;
`endif
                     end else begin
                        bit_cnt_r <= bit_cnt_r + BIT_ONE;
                     end
                  end else begin
                     tick_cnt_r <= tick_cnt_r + TICK_ONE;
                  end
               end
            end
            ST_PARITY: begin
               if (tick) begin
                  if (tick_cnt_r == TICK_LAST) begin
`ifdef UART_RX_PARITY_EN
                     parity_bit_r <= line_s;
`endif
                     tick_cnt_r <= TICK_ZERO;
                     state_r    <= ST_STOP;
                  end else begin
                     tick_cnt_r <= tick_cnt_r + TICK_ONE;
                  end
               end
            end
            ST_STOP: begin
               if (tick) begin
                  if (tick_cnt_r == TICK_LAST) begin
                     tick_cnt_r <= TICK_ZERO;
                     state_r    <= ST_IDLE;
                  end else begin
                     tick_cnt_r <= tick_cnt_r + TICK_ONE;
                  end
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               tick_cnt_r <= TICK_ZERO;
               bit_cnt_r  <= BIT_ZERO;
            end
         endcase
      end
   end

   // Output holding register with valid/ready handshake and overrun pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_data_r     <= '0;
         rx_valid_r    <= 1'b0;
         framing_err_r <= 1'b0;
         overrun_r     <= 1'b0;
      end else begin
         overrun_r <= 1'b0;
         if (load_s) begin
            rx_data_r     <= shreg_r;
            framing_err_r <= ~line_s;
            rx_valid_r    <= 1'b1;
         end else if (frame_done_s) begin
            // Held byte unaccepted: drop the new one, keep the old flags.
            overrun_r <= 1'b1;
         end else if (rx_valid_r && rx_ready) begin
            rx_valid_r <= 1'b0;
         end else begin
            rx_valid_r <= rx_valid_r;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   // Parity status captured alongside the byte it belongs to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         parity_err_r <= 1'b0;
      end else if (load_s) begin
         parity_err_r <= parity_mismatch(shreg_r, parity_bit_r);
      end else begin
         parity_err_r <= parity_err_r;
      end
   end

   assign parity_err = parity_err_r;
`else
   assign parity_err = 1'b0;
`endif

   assign rx_data     = rx_data_r;
   assign rx_valid    = rx_valid_r;
   assign framing_err = framing_err_r;
   assign overrun     = overrun_r;

endmodule : uart_receiver
